// File: rtl/auto_range_ctrl.sv
// rtl/auto_range_ctrl.sv - auto-ranging VGA gain controller with hysteresis, overload coarse-step and settle window
module auto_range_ctrl #(
  parameter int N_CH        = 4,
  parameter int SIG_W       = 16,
  parameter int GAIN_W      = 5,
  parameter int GAIN_MIN    = 0,
  parameter int GAIN_MAX    = 31,
  parameter int GAIN_RST    = 16,
  parameter int HI_THR      = 28000,
  parameter int LO_THR      = 8000,
  parameter int OVL_THR     = 32000,
  parameter int COARSE_STEP = 4,
  parameter int SETTLE_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    auto_enable,
  input  logic                    ready,
  input  logic [GAIN_W-1:0]       vga_in,
  input  logic [N_CH*SIG_W-1:0]   signal_max,
  output logic [GAIN_W-1:0]       vga_out,
  output logic                    vga_load,
  output logic                    busy,
  output logic                    at_limit
);

  typedef enum logic [1:0] {IDLE, EVAL, SETTLE} state_t;

  // Two guard bits so gain+1 at the top code and gain-COARSE_STEP at the bottom never overflow.
  localparam int AW    = GAIN_W + 2;
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [SIG_W-1:0]       HI_V    = SIG_W'(HI_THR);
  localparam logic [SIG_W-1:0]       LO_V    = SIG_W'(LO_THR);
  localparam logic [SIG_W-1:0]       OVL_V   = SIG_W'(OVL_THR);
  localparam logic signed [AW-1:0]   G_MIN_S = AW'(GAIN_MIN);
  localparam logic signed [AW-1:0]   G_MAX_S = AW'(GAIN_MAX);
  localparam logic signed [AW-1:0]   STEP_S  = AW'(COARSE_STEP);
  localparam logic signed [AW-1:0]   ONE_S   = AW'(1);
  localparam logic [GAIN_W-1:0]      G_MIN_U = GAIN_W'(GAIN_MIN);
  localparam logic [GAIN_W-1:0]      G_MAX_U = GAIN_W'(GAIN_MAX);
  localparam logic [GAIN_W-1:0]      G_RST_U = GAIN_W'(GAIN_RST);
  localparam logic [CNT_W-1:0]       CNT_LD  = CNT_W'(SETTLE_CYC - 1);

  state_t              state;
  logic [SIG_W-1:0]    peak;
  logic [SIG_W-1:0]    peak_in;
  logic [CNT_W-1:0]    cnt;
  logic signed [AW-1:0] g_cur;
  logic signed [AW-1:0] g_next;
  logic [GAIN_W-1:0]   gain_next;

  always_comb begin
    peak_in = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (signal_max[i*SIG_W +: SIG_W] > peak_in) peak_in = signal_max[i*SIG_W +: SIG_W];
    end
  end

  always_comb begin
    g_cur  = $signed({2'b00, vga_out});
    g_next = g_cur;
    if (peak >= OVL_V)     g_next = g_cur - STEP_S;
    else if (peak > HI_V)  g_next = g_cur - ONE_S;
    else if (peak < LO_V)  g_next = g_cur + ONE_S;
    if (g_next < G_MIN_S)      g_next = G_MIN_S;
    else if (g_next > G_MAX_S) g_next = G_MAX_S;
    gain_next = g_next[GAIN_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      peak     <= '0;
      cnt      <= '0;
      vga_out  <= G_RST_U;
      vga_load <= 1'b0;
    end else if (!auto_enable) begin
      state    <= IDLE;
      cnt      <= '0;
      vga_out  <= vga_in;
      vga_load <= (vga_in != vga_out);
    end else begin
      vga_load <= 1'b0;
      case (state)
        IDLE: begin
          if (ready) begin
            peak  <= peak_in;
            state <= EVAL;
          end
        end
        EVAL: begin
          if (gain_next != vga_out) begin
            vga_out  <= gain_next;
            vga_load <= 1'b1;
            cnt      <= CNT_LD;
            state    <= SETTLE;
          end else begin
            state <= IDLE;
          end
        end
        SETTLE: begin
          // ready is ignored here: measurements taken while the VGA settles are stale.
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign at_limit = (vga_out == G_MIN_U) || (vga_out == G_MAX_U);

endmodule
